// File: rtl/music_pkg.sv
// Shared types, constants and helpers for the music sequencer.
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] END_MARKER = 4'hF;
    localparam logic [3:0] NOTE_REST  = 4'h0;

    // Bit positions inside an 8-bit music word.
    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 4;
    localparam int OCT_MSB  = 3;
    localparam int OCT_LSB  = 2;
    localparam int DUR_MSB  = 1;
    localparam int DUR_LSB  = 0;

    // Duration index to number of tempo units.
    function automatic logic [3:0] duration_units(input logic [1:0] idx);
        case (idx)
            2'b00:   duration_units = 4'd1;
            2'b01:   duration_units = 4'd2;
            2'b10:   duration_units = 4'd4;
            default: duration_units = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Control, song ROM and tone generator signals of the music sequencer.
interface music_sequencer_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  pause;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [7:0]            rom_data;
    logic [3:0]            note;
    logic [1:0]            octave;
    logic                  note_valid;
    logic                  playing;
    logic                  done;

    // Host side: issues commands, returns ROM data, consumes the note.
    modport master (
        output start, start_addr, pause, stop, rom_data,
        input  rom_addr, note, octave, note_valid, playing, done
    );

    // Sequencer side.
    modport slave (
        input  start, start_addr, pause, stop, rom_data,
        output rom_addr, note, octave, note_valid, playing, done
    );
endinterface

// File: rtl/music_sequencer.sv
// Walks the song ROM word by word, decoding each word into a note that is
// held for its duration in tempo units. FSM, address register and duration
// counter live together here.
//
// state | meaning
// IDLE  | waiting for start, rom_addr holds last value
// FETCH | rom_addr stable, ROM read in flight
// LOAD  | rom_data decoded, counter loaded (or end marker seen)
// PLAY  | duration counter running, frozen while paused
// DONE  | one-cycle done pulse, outputs cleared
module music_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int TICK_CYCLES = 6250000
) (
    input  logic              clk,
    input  logic              reset,
    music_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(8 * TICK_CYCLES);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            note_q;
    logic [1:0]            octave_q;
    logic                  note_valid_q;
    logic                  playing_q;
    logic                  done_q;

    logic [3:0]            word_note_d;
    logic [1:0]            word_oct_d;
    logic [1:0]            word_dur_d;
    logic [3:0]            note_d;
    logic [CNT_W-1:0]      cnt_load_d;

    // Decode the ROM word; codes 13 and 14 collapse to a rest.
    always_comb begin
        word_note_d = bus.rom_data[NOTE_MSB:NOTE_LSB];
        word_oct_d  = bus.rom_data[OCT_MSB:OCT_LSB];
        word_dur_d  = bus.rom_data[DUR_MSB:DUR_LSB];
        note_d      = (word_note_d >= 4'd13) ? NOTE_REST : word_note_d;
        cnt_load_d  = CNT_W'(int'(duration_units(word_dur_d)) * TICK_CYCLES - 1);
    end

    // Sequencer FSM with registered outputs, address and duration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            cnt_q        <= '0;
            note_q       <= NOTE_REST;
            octave_q     <= 2'd0;
            note_valid_q <= 1'b0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != ST_IDLE && bus.stop) begin
                state_q      <= ST_IDLE;
                note_q       <= NOTE_REST;
                octave_q     <= 2'd0;
                note_valid_q <= 1'b0;
                playing_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            rom_addr_q <= bus.start_addr;
                            state_q    <= ST_FETCH;
                            playing_q  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (word_note_d == END_MARKER) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            note_q       <= NOTE_REST;
                            octave_q     <= 2'd0;
                            note_valid_q <= 1'b0;
                        end else begin
                            state_q      <= ST_PLAY;
                            note_q       <= note_d;
                            octave_q     <= word_oct_d;
                            note_valid_q <= (note_d != NOTE_REST);
                            cnt_q        <= cnt_load_d;
                        end
                    end
                    ST_PLAY: begin
                        // Pause freezes the counter and mutes, keeping the note.
                        if (bus.pause) begin
                            note_valid_q <= 1'b0;
                        end else begin
                            note_valid_q <= (note_q != NOTE_REST);
                            if (cnt_q == '0) begin
                                if (rom_addr_q == '1) begin
                                    state_q      <= ST_DONE;
                                    done_q       <= 1'b1;
                                    note_q       <= NOTE_REST;
                                    octave_q     <= 2'd0;
                                    note_valid_q <= 1'b0;
                                end else begin
                                    rom_addr_q <= rom_addr_q + 1'b1;
                                    state_q    <= ST_FETCH;
                                end
                            end else begin
                                cnt_q <= cnt_q - 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q   <= ST_IDLE;
                        playing_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        playing_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.note       = note_q;
    assign bus.octave     = octave_q;
    assign bus.note_valid = note_valid_q;
    assign bus.playing    = playing_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with TICK_CYCLES=4 and a 1-cycle ROM.
module tb_music_sequencer;

    localparam int AW = 24;
    localparam int TC = 4;

    logic clk;
    logic reset;

    music_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    music_sequencer #(.ADDR_WIDTH(AW), .TICK_CYCLES(TC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural song ROM, one cycle of read latency; unwritten words are end markers.
    logic [7:0] rom_mem [logic [AW-1:0]];
    always @(posedge clk)
        bus.rom_data <= rom_mem.exists(bus.rom_addr) ? rom_mem[bus.rom_addr] : 8'hF0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cnt = 0;

    always @(negedge clk)
        if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Start pulse lands on cycle 0; returns in cycle 1.
    task automatic do_start(input logic [AW-1:0] a);
        bus.start_addr = a;
        bus.start      = 1'b1;
        cyc            = 0;
        tick();
        bus.start      = 1'b0;
    endtask

    typedef struct {
        logic [7:0] word;
        int         units;
        logic [3:0] exp_note;
        logic [1:0] exp_oct;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int d0;

        vecs[0] = '{8'h14, 1, 4'd1,  2'd1, 1'b1};
        vecs[1] = '{8'h29, 2, 4'd2,  2'd2, 1'b1};
        vecs[2] = '{8'h3A, 4, 4'd3,  2'd2, 1'b1};
        vecs[3] = '{8'hCF, 8, 4'd12, 2'd3, 1'b1};
        vecs[4] = '{8'h03, 8, 4'd0,  2'd0, 1'b0};
        vecs[5] = '{8'hD1, 2, 4'd0,  2'd0, 1'b0};
        for (int i = 0; i < 6; i++) rom_mem[AW'(10 + i)] = vecs[i].word;
        rom_mem[AW'(16)]     = 8'hF0;
        rom_mem[AW'(200)]    = 8'h5A;
        rom_mem[AW'(201)]    = 8'hF0;
        rom_mem[AW'(300)]    = 8'h14;
        rom_mem[AW'(301)]    = 8'h29;
        rom_mem[AW'(302)]    = 8'hF0;
        rom_mem[AW'(400)]    = 8'hCF;
        rom_mem[24'hFFFFFF]  = 8'h27;

        bus.start = 1'b0; bus.start_addr = '0; bus.pause = 1'b0; bus.stop = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_addr",    32'(bus.rom_addr), 32'h0);
        chk("rst_note",    32'(bus.note), 32'h0);
        chk("rst_octave",  32'(bus.octave), 32'h0);
        chk("rst_valid",   32'(bus.note_valid), 32'h0);
        chk("rst_playing", 32'(bus.playing), 32'h0);
        chk("rst_done",    32'(bus.done), 32'h0);

        // Table: consecutive words starting at address 10.
        d0 = done_cnt;
        do_start(AW'(10));
        chk("fetch_playing", 32'(bus.playing), 32'h1);
        base = 3;
        for (int i = 0; i < 6; i++) begin
            run_to(base);
            chk($sformatf("v%0d_note", i),    32'(bus.note),       32'(vecs[i].exp_note));
            chk($sformatf("v%0d_oct", i),     32'(bus.octave),     32'(vecs[i].exp_oct));
            chk($sformatf("v%0d_valid", i),   32'(bus.note_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_playing", i), 32'(bus.playing),    32'h1);
            run_to(base + vecs[i].units * TC + 1);
            chk($sformatf("v%0d_hold_note", i), 32'(bus.note),   32'(vecs[i].exp_note));
            chk($sformatf("v%0d_hold_oct", i),  32'(bus.octave), 32'(vecs[i].exp_oct));
            chk($sformatf("v%0d_nodone", i),    32'(bus.done),   32'h0);
            base += vecs[i].units * TC + 2;
        end
        run_to(base);
        chk("end_done",    32'(bus.done), 32'h1);
        chk("end_note",    32'(bus.note), 32'h0);
        chk("end_playing", 32'(bus.playing), 32'h1);
        tick();
        chk("end_done_drop",    32'(bus.done), 32'h0);
        chk("end_playing_drop", 32'(bus.playing), 32'h0);
        chk("end_addr_held",    32'(bus.rom_addr), 32'd16);
        chk("end_done_count",   32'(done_cnt - d0), 32'd1);

        // Pause for 5 cycles inside a 16-cycle note.
        do_start(AW'(200));
        run_to(6);
        chk("p_valid_before", 32'(bus.note_valid), 32'h1);
        bus.pause = 1'b1;
        for (int c = 7; c <= 11; c++) begin
            run_to(c);
            chk($sformatf("p_valid_c%0d", c), 32'(bus.note_valid), 32'h0);
            chk($sformatf("p_note_c%0d", c),  32'(bus.note),       32'h5);
            chk($sformatf("p_oct_c%0d", c),   32'(bus.octave),     32'h2);
        end
        bus.pause = 1'b0;
        run_to(12);
        chk("p_valid_after", 32'(bus.note_valid), 32'h1);
        run_to(23);
        chk("p_last_cycle_note", 32'(bus.note), 32'h5);
        run_to(25);
        chk("p_no_early_done", 32'(bus.done), 32'h0);
        run_to(26);
        chk("p_done", 32'(bus.done), 32'h1);
        tick();

        // Stop during the second note, with a start in the same cycle.
        d0 = done_cnt;
        do_start(AW'(300));
        run_to(10);
        chk("s_second_note", 32'(bus.note), 32'h2);
        run_to(11);
        bus.stop = 1'b1; bus.start = 1'b1; bus.start_addr = AW'(500);
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("s_note",    32'(bus.note), 32'h0);
        chk("s_octave",  32'(bus.octave), 32'h0);
        chk("s_valid",   32'(bus.note_valid), 32'h0);
        chk("s_playing", 32'(bus.playing), 32'h0);
        repeat (4) tick();
        chk("s_still_idle", 32'(bus.playing), 32'h0);
        chk("s_addr_held",  32'(bus.rom_addr), 32'd301);
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        tick();
        chk("s_idle_startstop", 32'(bus.playing), 32'h0);
        chk("s_idle_addr",      32'(bus.rom_addr), 32'd301);
        chk("s_no_done",        32'(done_cnt - d0), 32'd0);

        // Last ROM address: play the word, then done without wrapping.
        do_start(24'hFFFFFF);
        run_to(3);
        chk("a_note",  32'(bus.note), 32'h2);
        chk("a_oct",   32'(bus.octave), 32'h1);
        chk("a_valid", 32'(bus.note_valid), 32'h1);
        run_to(34);
        chk("a_last_play", 32'(bus.note), 32'h2);
        chk("a_no_done",   32'(bus.done), 32'h0);
        run_to(35);
        chk("a_done", 32'(bus.done), 32'h1);
        chk("a_addr", 32'(bus.rom_addr), 32'hFFFFFF);
        tick();
        chk("a_idle", 32'(bus.playing), 32'h0);
        chk("a_addr_nowrap", 32'(bus.rom_addr), 32'hFFFFFF);

        // Asynchronous reset in the middle of PLAY.
        do_start(AW'(400));
        run_to(5);
        chk("r_valid_before", 32'(bus.note_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_note",    32'(bus.note), 32'h0);
        chk("r_octave",  32'(bus.octave), 32'h0);
        chk("r_valid",   32'(bus.note_valid), 32'h0);
        chk("r_playing", 32'(bus.playing), 32'h0);
        chk("r_addr",    32'(bus.rom_addr), 32'h0);
        chk("r_done",    32'(bus.done), 32'h0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("r_wait_start", 32'(bus.playing), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
